idu_issue_queue: RTL
====================

# idu_issue_queue

Parametrised decode-front block between the IFU and the instruction decoder. It buffers fetched (pc, inst) pairs in a DEPTH-entry FIFO. A per-register scoreboard tracks up to 2^CNT_W−1 outstanding writes per GPR, replacing the single "EXU pending rd" compare with multi-writer, multi-writeback tracking. The head entry is issued downstream only when none of its GPR sources is pending and its destination counter can accept another write.

## Interface
Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥ 2.
- NUM_WB, 2: number of writeback ports, ≥ 1.
- CNT_W, 2: width of each per-register pending counter, ≥ 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low. 0 = reset asserted.
- flush  in  1  discard all queued entries this cycle.
- in_valid  in  1  IFU entry valid.
- in_ready  out  1  FIFO can accept an entry.
- in_pc  in  32  fetch PC.
- in_inst  in  32  fetched instruction.
- out_valid  out  1  head entry issuable.
- out_ready  in  1  decoder accepts the head entry.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- out_rs1  out  5  inst[19:15] of the head entry.
- out_rs2  out  5  inst[24:20] of the head entry.
- out_rd  out  5  destination register; 0 for BRANCH/STORE.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_rd  in  5*NUM_WB  port i destination at bits [5i+4:5i].
- count  out  $clog2(DEPTH)+1  current occupancy.
- stall_raw  out  1  head is blocked by a pending source or a saturated destination counter.

## Operation
- **Opcode** is inst[6:2]:
  - JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000.
  - OP-IMM 00100, OP 01100, SYSTEM 11100.
- **need_rs1** is set for JALR, BRANCH, LOAD, STORE, OP-IMM and OP. For SYSTEM it is set when funct3 != 0 and funct3[2] == 0.
- **need_rs2** is set for BRANCH, STORE and OP.
- **Destination**: out_rd = inst[11:7], except BRANCH/STORE, which give 0. Register x0 is never tracked, never blocks and is never counted.
- **Scoreboard**: one counter per x1..x31, CNT_W bits wide, reset to 0.
  - Increment by 1 on issue (out_valid & out_ready) when out_rd != 0.
  - Decrement by k, where k is the number of ports i with wb_valid[i] and wb_rd[i] == r (r != 0).
  - Increment and decrements to the same register in the same cycle are applied as a net change.
  - A decrement that would go below 0 clamps at 0. This is a protocol error, and verification asserts it never occurs.
- **Stall conditions**:
  - raw = (need_rs1 & rs1 != 0 & cnt[rs1] != 0) | (need_rs2 & rs2 != 0 & cnt[rs2] != 0).
  - sat = out_rd != 0 & cnt[out_rd] == 2^CNT_W−1.
  - stall_raw = nonempty & (raw | sat).
  - Counters are read as registered values only; there is no same-cycle writeback bypass.
- **out_valid** = nonempty & ~flush & ~stall_raw.
- **in_ready** = ~full & ~flush. Enqueue happens on in_valid & in_ready. There is no pass-through path: an entry enqueued in cycle t is first at the head in cycle t+1.
- **FIFO mechanics**:
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty are derived from count.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - When full, an enqueue is blocked by in_ready even if a dequeue occurs the same cycle.
- **flush**:
  - Next cycle: count = 0, pointers = 0, no issue occurs in the flush cycle.
  - The scoreboard is untouched: in-flight writers are older than the flushing branch and still write back.
- **Outputs while empty**: out_pc, out_inst and the derived fields are don't-care. They carry the stale slot contents and are not required to be 0.

## Timing
- While reset is 0, and after its release:
  - count = 0, out_valid = 0, stall_raw = 0, in_ready = 1.
  - All counters = 0. FIFO storage is not reset.
- Reset asserted mid-operation: all state returns to the above asynchronously, within the same cycle.
- Minimum latency in → out: 1 cycle. Throughput: 1 issue/cycle when no hazards.
- A hazard cleared by writeback in cycle t lets the head issue in cycle t+1 at the earliest.
- out_valid and the head fields stay stable while out_valid & ~out_ready, unless flush is asserted.

## Test plan
- **Fill/drain**, DEPTH=4:
  - Stimulus: push 5 ADDI with out_ready=0.
  - Required: in_ready drops after the 4th push and count = 4. Then raise out_ready: issue in order, one per cycle, and count reaches 0 after 4 cycles.
- **RAW stall**:
  - Stimulus: issue `addi x5,x0,1`, then queue `add x6,x5,x5`.
  - Required: stall_raw = 1 and out_valid = 0. Assert wb_valid[0] with wb_rd=5 at cycle t: out_valid = 1 at t+1.
- **Multi-writer and saturation**, CNT_W=2:
  - Stimulus: issue three writes to x7.
  - Required: the 4th `addi x7` stalls via sat. Drive two writebacks to x7 on ports 0 and 1 in the same cycle: cnt[x7] goes 3→1 and the 4th instruction issues next cycle.
- **x0 and store**:
  - Stimulus: `sw x0,0(x0)`, then `addi x0,x0,0`.
  - Required: never stall, no counter changes, out_rd = 0 for both.
- **Flush**:
  - Stimulus: 3 entries queued with x9 pending; assert flush for 1 cycle with in_valid = 1.
  - Required: out_valid = 0 in that cycle, count = 0 next cycle, the incoming entry is not enqueued, and cnt[x9] is unchanged.
- **Async reset mid-stream**:
  - Stimulus: pull reset low between clock edges while count = 2 and counters are nonzero.
  - Required: count = 0 and out_valid = 0 immediately; all counters are 0 at release.

Source files
------------

// File: rtl/idu_issue_queue.sv
// Decode-front issue queue: buffers fetched (pc, inst) pairs and issues the head
// only when a per-GPR pending-write scoreboard shows no RAW hazard or saturation.
module idu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [5*NUM_WB-1:0]       wb_rd,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      stall_raw
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_cnt  [32];

  logic [31:0]      w_head_inst;
  logic [4:0]       w_opc;
  logic [2:0]       w_funct3;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic             w_need_rs1;
  logic             w_need_rs2;
  logic             w_no_rd;
  logic             w_nonempty;
  logic             w_full;
  logic             w_raw;
  logic             w_sat;
  logic             w_stall;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic [15:0]      w_dec     [32];
  logic [15:0]      w_sum     [32];
  logic [CNT_W-1:0] w_cnt_nxt [32];

  // FIFO storage is intentionally not reset; only pointers and count are.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc[r_tail]   <= in_pc;
      r_inst[r_tail] <= in_inst;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_inst = r_inst[r_head];
  assign w_opc       = w_head_inst[6:2];
  assign w_funct3    = w_head_inst[14:12];
  assign w_rs1       = w_head_inst[19:15];
  assign w_rs2       = w_head_inst[24:20];

  always_comb begin
    w_need_rs1 = 1'b0;
    w_need_rs2 = 1'b0;
    w_no_rd    = 1'b0;
    case (w_opc)
      OPC_JALR:   w_need_rs1 = 1'b1;
      OPC_BRANCH: begin
        w_need_rs1 = 1'b1;
        w_need_rs2 = 1'b1;
        w_no_rd    = 1'b1;
      end
      OPC_LOAD:   w_need_rs1 = 1'b1;
      OPC_STORE:  begin
        w_need_rs1 = 1'b1;
        w_need_rs2 = 1'b1;
        w_no_rd    = 1'b1;
      end
      OPC_OPIMM:  w_need_rs1 = 1'b1;
      OPC_OP:     begin
        w_need_rs1 = 1'b1;
        w_need_rs2 = 1'b1;
      end
      // CSR register forms read rs1; immediate forms and ECALL/EBREAK do not.
      OPC_SYSTEM: w_need_rs1 = (w_funct3 != 3'b000) && !w_funct3[2];
      default:    ;
    endcase
  end

  assign w_rd = w_no_rd ? 5'd0 : w_head_inst[11:7];

  assign w_nonempty  = (r_count != '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_raw       = (w_need_rs1 && (w_rs1 != 5'd0) && (r_cnt[w_rs1] != '0)) ||
                       (w_need_rs2 && (w_rs2 != 5'd0) && (r_cnt[w_rs2] != '0));
  assign w_sat       = (w_rd != 5'd0) && (r_cnt[w_rd] == CNT_MAX);
  assign w_stall     = w_nonempty && (w_raw || w_sat);
  assign w_out_valid = w_nonempty && !flush && !w_stall;
  assign w_in_ready  = !w_full && !flush;
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Net per-register change: +1 for an issuing writer, -k for k matching writebacks.
  // Saturation blocks the increment at CNT_MAX, so the sum never overflows CNT_W.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      w_dec[r] = '0;
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && (wb_rd[5*i +: 5] == 5'(r)))
          w_dec[r] = w_dec[r] + 16'd1;
      end
      w_sum[r] = 16'(r_cnt[r]);
      if (w_pop && (w_rd == 5'(r)))
        w_sum[r] = w_sum[r] + 16'd1;
      if (r == 0)
        w_cnt_nxt[r] = '0;
      else if (w_sum[r] > w_dec[r])
        w_cnt_nxt[r] = CNT_W'(w_sum[r] - w_dec[r]);
      else
        w_cnt_nxt[r] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_pc    = r_pc[r_head];
  assign out_inst  = w_head_inst;
  assign out_rs1   = w_rs1;
  assign out_rs2   = w_rs2;
  assign out_rd    = w_rd;
  assign count     = r_count;
  assign stall_raw = w_stall;

endmodule
